// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped level-interrupt controller.
// Collects NumSrc level sources into one core interrupt line. Each source has
// a pending bit, an enable bit and an in-service bit. The core claims the
// lowest-numbered enabled pending source by reading CLAIM and completes it by
// writing the ID back, so each assertion of a source is serviced exactly once.
// Bus slave: one response per request, exactly one cycle later, no stalls.

module irq_ctrl #(
   parameter int unsigned NumSrc       = 8,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // bus slave
   input  logic                    irq_req_i,
   input  logic [AddressWidth-1:0] irq_addr_i,
   input  logic                    irq_we_i,
   input  logic [DataWidth/8-1:0]  irq_be_i,
   input  logic [DataWidth-1:0]    irq_wdata_i,
   output logic                    irq_rvalid_o,
   output logic [DataWidth-1:0]    irq_rdata_o,
   output logic                    irq_err_o,
   // interrupt sources and core request
   input  logic [NumSrc-1:0]       irq_src_i,
   output logic                    irq_o
);

   // Source IDs are 1..NumSrc (NumSrc <= 31), so five bits always suffice.
   localparam int unsigned IdW = 5;

   localparam logic [9:0] OffPending   = 10'h000;
   localparam logic [9:0] OffEnable    = 10'h004;
   localparam logic [9:0] OffClaim     = 10'h008;
   localparam logic [9:0] OffInService = 10'h00C;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [NumSrc-1:0]    pending_q,    pending_d;
   logic [NumSrc-1:0]    in_service_q, in_service_d;
   logic [NumSrc-1:0]    enable_q,     enable_d;
   logic                 irq_q;
   logic                 rvalid_q;
   logic [DataWidth-1:0] rdata_q,      rdata_d;
   logic                 err_q;

   // ------------------------------------------------------------------
   // Address decode (only the low 10 bits select a register)
   // ------------------------------------------------------------------
   logic [9:0] offset;
   logic       sel_pending, sel_enable, sel_claim, sel_in_service, sel_mapped;
   logic       rd_req, wr_req;
   logic       bus_err;
   logic       claim, complete, enable_wr;

   assign offset         = irq_addr_i[9:0];
   assign sel_pending    = (offset == OffPending);
   assign sel_enable     = (offset == OffEnable);
   assign sel_claim      = (offset == OffClaim);
   assign sel_in_service = (offset == OffInService);
   assign sel_mapped     = sel_pending | sel_enable | sel_claim | sel_in_service;

   assign rd_req = irq_req_i & ~irq_we_i;
   assign wr_req = irq_req_i &  irq_we_i;

   // Unmapped offsets and writes to read-only registers are errors; every
   // side-effecting strobe below requires a legal offset, so errored
   // requests never modify state.
   assign bus_err = ~sel_mapped | (irq_we_i & (sel_pending | sel_in_service));

   assign claim     = rd_req & sel_claim;
   assign complete  = wr_req & sel_claim & irq_be_i[0];
   assign enable_wr = wr_req & sel_enable;

   // ------------------------------------------------------------------
   // Claim arbitration: lowest-numbered source that is pending and enabled
   // ------------------------------------------------------------------
   logic [NumSrc-1:0] eligible;
   logic              best_found;
   logic [IdW-1:0]    best_idx;
   logic [IdW-1:0]    claim_id;
   logic [IdW-1:0]    cmpl_id;

   assign eligible = pending_q & enable_q;

   // Priority encoder; scanning downward lets the lowest index win.
   always_comb begin
      best_found = 1'b0;
      best_idx   = '0;
      for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            best_found = 1'b1;
            best_idx   = IdW'(i);
         end
      end
   end

   assign claim_id = best_found ? (best_idx + IdW'(1)) : '0;
   assign cmpl_id  = irq_wdata_i[IdW-1:0];

   // ------------------------------------------------------------------
   // Per-source gateway, in-service tracking and enable byte lanes
   // ------------------------------------------------------------------
   logic [NumSrc-1:0] claim_clr;
   logic [NumSrc-1:0] cmpl_clr;

   generate
      for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
         // A claim in this cycle targets exactly this source.
         assign claim_clr[gi] = claim & best_found & (best_idx == IdW'(gi));
         // Complete matches ID gi+1; IDs 0 and >NumSrc match nothing.
         assign cmpl_clr[gi]  = complete & (cmpl_id == IdW'(gi + 1));

         // In-service masks new sets; a claim clear beats a same-cycle set.
         assign pending_d[gi] = (pending_q[gi] | (irq_src_i[gi] & ~in_service_q[gi]))
                                & ~claim_clr[gi];

         // Completing a source that is not in service is a harmless no-op.
         assign in_service_d[gi] = (in_service_q[gi] & ~cmpl_clr[gi]) | claim_clr[gi];

         // Enable bit gi lives in byte lane gi/8.
         assign enable_d[gi] = (enable_wr & irq_be_i[gi / 8]) ? irq_wdata_i[gi]
                                                              : enable_q[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read data mux (writes and errored requests return zero)
   // ------------------------------------------------------------------
   always_comb begin
      rdata_d = '0;
      if (rd_req) begin
         case (offset)
            OffPending:   rdata_d[NumSrc-1:0] = pending_q;
            OffEnable:    rdata_d[NumSrc-1:0] = enable_q;
            OffClaim:     rdata_d[IdW-1:0]    = claim_id;
            OffInService: rdata_d[NumSrc-1:0] = in_service_q;
            default:      rdata_d             = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Interrupt bookkeeping registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q    <= '0;
         in_service_q <= '0;
         enable_q     <= '0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         enable_q     <= enable_d;
      end
   end

   // Core interrupt flop; tracks |(pending_q & enable_q) with no combinational path.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(pending_d & enable_d);
      end
   end

   // Bus response: valid one cycle after each request; data/err load only on requests.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= irq_req_i;
         if (irq_req_i) begin
            rdata_q <= rdata_d;
            err_q   <= bus_err;
         end
      end
   end

   assign irq_o        = irq_q;
   assign irq_rvalid_o = rvalid_q;
   assign irq_rdata_o  = rdata_q;
   assign irq_err_o    = err_q;

   // Upper address bits and unused data/byte-enable lanes are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{irq_addr_i, irq_wdata_i, irq_be_i};

endmodule
